// File: rtl/mul_exec_ctrl_pkg.sv
// Shared types and defaults for the integer multiply execution lane.
package mul_exec_ctrl_pkg;

  localparam int MUL_LAT  = 3;
  localparam int MUL_XLEN = 64;

  typedef logic [MUL_XLEN-1:0] word_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } mul_op_t;

  // src1 is treated as signed for MULH and MULHSU; MUL keeps only the low
  // half, where operand signedness makes no difference.
  function automatic logic src1_signed(input mul_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  // src2 is treated as signed only for MULH (and MUL, where it is irrelevant).
  function automatic logic src2_signed(input mul_op_t op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mul_exec_ctrl_datapath.sv
// Multiply datapath: operand extension, product pipelined over LAT stages,
// and result selection by op at the last stage.
module mul_datapath
  import mul_exec_ctrl_pkg::*;
#(
  parameter int XLEN = MUL_XLEN,
  parameter int LAT  = MUL_LAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [LAT:1]    en,
  input  mul_op_t         issue_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  mul_op_t         sel_op,
  output logic [XLEN-1:0] result
);

  localparam int OW = XLEN + 1;
  localparam int PW = 2 * XLEN;

  logic [OW-1:0] a_ext;
  logic [OW-1:0] b_ext;
  logic [OW-1:0] a_q;
  logic [OW-1:0] b_q;
  logic [PW-1:0] a_wide;
  logic [PW-1:0] b_wide;
  logic [PW-1:0] prod_full;
  logic [PW-1:0] prod [2:LAT];
  logic [PW-1:0] p_last;

  // Extend each operand by one bit according to the signedness of the op.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    a_ext = '0;
    b_ext = '0;
    if (issue_op == OP_MULW) begin
      a_ext = {{(OW-32){1'b0}}, src1[31:0]};
      b_ext = {{(OW-32){1'b0}}, src2[31:0]};
    end else begin
      a_ext = {src1_signed(issue_op) & src1[XLEN-1], src1};
      b_ext = {src2_signed(issue_op) & src2[XLEN-1], src2};
    end
  end

  // Stage 1 captures the extended operands on the issue handshake.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (en[1]) begin
      a_q <= a_ext;
      b_q <= b_ext;
    end
  end

  // Sign-extend to the full product width; the truncated unsigned product
  // then equals the low 2*XLEN bits of the signed product.
  assign a_wide    = {{(PW-OW){a_q[OW-1]}}, a_q};
  assign b_wide    = {{(PW-OW){b_q[OW-1]}}, b_q};
  assign prod_full = a_wide * b_wide;

  // Stages 2..LAT carry the product forward as the control advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the product pipeline is reset (not left uninitialised) because wb_data must read zero out of reset.
      for (int k = 2; k <= LAT; k++) prod[k] <= '0;
    end else begin
      if (en[2]) prod[2] <= prod_full;
      for (int k = 3; k <= LAT; k++) begin
        if (en[k]) prod[k] <= prod[k-1];
      end
    end
  end

  assign p_last = prod[LAT];

  // Pick the result half (or the sign-extended word) for the op in the last stage.
  always_comb begin
    result = '0;
    case (sel_op)
      OP_MUL:                       result = p_last[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = p_last[PW-1:XLEN];
      OP_MULW:                      result = {{(XLEN-32){p_last[31]}}, p_last[31:0]};
      default:                      result = '0;
    endcase
  end

endmodule

// File: rtl/mul_exec_ctrl.sv
// Control for the integer multiply lane: stage valids and tags, bubble
// collapsing advance, writeback back-pressure, wake request and flush.
module mul_exec_ctrl
  import mul_exec_ctrl_pkg::*;
#(
  parameter int LAT    = MUL_LAT,
  parameter int XLEN   = MUL_XLEN,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  mul_op_t           issue_op,
  input  logic [XLEN-1:0]   issue_src1,
  input  logic [XLEN-1:0]   issue_src2,
  input  logic [PREG_W-1:0] issue_dst,
  input  logic [ROB_W-1:0]  issue_rob,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [PREG_W-1:0] wb_dst,
  output logic [ROB_W-1:0]  wb_rob,
  output logic              wake_valid,
  output logic [PREG_W-1:0] wake_dst,
  output logic              busy
);

  typedef struct packed {
    logic              valid;
    mul_op_t           op;
    logic [PREG_W-1:0] dst;
    logic [ROB_W-1:0]  rob;
  } mul_stage_t;

  mul_stage_t   st [1:LAT];
  logic [LAT:1] v;
  logic [LAT:1] adv;
  logic [LAT:1] en;
  logic         issue_fire;
  logic         chain;

  // Gather the stage valid bits into one vector.
  always_comb begin
    v = '0;
    for (int k = 1; k <= LAT; k++) v[k] = st[k].valid;
  end

  // A stage advances unless it and every stage ahead of it are full while
  // writeback is stalled; equivalent to the recursive bubble-collapse rule
  // but free of a combinational chain through the adv vector itself.
  always_comb begin
    adv   = '0;
    chain = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      chain = 1'b1;
      for (int j = k + 1; j <= LAT; j++) chain = chain & v[j];
      adv[k] = v[k] & ~(chain & ~wb_ready);
    end
  end

  assign issue_ready = ~flush & (~v[1] | adv[1]);
  assign issue_fire  = issue_valid & issue_ready;

  // Datapath stage k loads whenever its control stage loads.
  always_comb begin
    en    = '0;
    en[1] = issue_fire;
    for (int k = 2; k <= LAT; k++) en[k] = adv[k-1];
  end

  // Stage control registers: load on advance from behind, drain on advance
  // forward, hold otherwise; flush kills every valid on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= LAT; k++) st[k] <= '0;
    end else begin
      if (issue_fire) begin
        st[1] <= '{valid: 1'b1, op: issue_op, dst: issue_dst, rob: issue_rob};
      end else if (adv[1]) begin
        st[1].valid <= 1'b0;
      end
      for (int k = 2; k <= LAT; k++) begin
        if (adv[k-1]) st[k] <= st[k-1];
        else if (adv[k]) st[k].valid <= 1'b0;
      end
      if (flush) begin
        for (int k = 1; k <= LAT; k++) st[k].valid <= 1'b0;
      end
    end
  end

  mul_datapath #(
    .XLEN (XLEN),
    .LAT  (LAT)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .issue_op (issue_op),
    .src1     (issue_src1),
    .src2     (issue_src2),
    .sel_op   (st[LAT].op),
    .result   (wb_data)
  );

  assign wb_valid   = st[LAT].valid;
  assign wb_dst     = st[LAT].dst;
  assign wb_rob     = st[LAT].rob;
  assign wake_valid = wb_valid & wb_ready;
  assign wake_dst   = wb_dst;
  assign busy       = |v;

endmodule
